hazard_scoreboard: RTL and testbench

- Parametrised hazard and forwarding unit for the in-order pipeline. It is the successor to the decode-stage fixed 3-stage, stall-only detector.
- Tracks in-flight destination registers in a PIPE_DEPTH-deep shift register, one slot per stage after ID.
- Every cycle it produces a stall for ID and per-operand forwarding selects for EX.
- Supports stall-only mode (FWD_EN=0) and forwarding mode with load-use stall (FWD_EN=1). Includes a saturating stall-cycle counter for CPI analysis.

---
 rtl/hazard_scoreboard.sv | 137 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding unit: tracks in-flight destination registers per pipeline slot
// and produces the ID stall plus EX forwarding selects each cycle.
module hazard_scoreboard #(
  parameter int NUM_REGS      = 32,
  parameter int IDX_W         = 5,
  parameter int PIPE_DEPTH    = 3,
  parameter int FWD_EN        = 1,
  parameter int WB_BYPASS     = 0,
  parameter int LOAD_FWD_SLOT = 2,
  parameter int CNT_W         = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              id_valid,
  input  logic [IDX_W-1:0]                  id_ra_idx,
  input  logic [IDX_W-1:0]                  id_rb_idx,
  input  logic                              id_ra_used,
  input  logic                              id_rb_used,
  input  logic [IDX_W-1:0]                  id_dest_idx,
  input  logic                              id_reg_wr,
  input  logic                              id_rd_mem,
  input  logic                              flush,
  output logic                              stall,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]   fwd_a_sel,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]   fwd_b_sel,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]   inflight_cnt,
  output logic [CNT_W-1:0]                  stall_cycles
);

  localparam int SEL_W = $clog2(PIPE_DEPTH + 1);

  if ((2 ** IDX_W) < NUM_REGS) begin : g_bad_idx_w
    $error("hazard_scoreboard: IDX_W too small for NUM_REGS");
  end
  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_depth
    $error("hazard_scoreboard: PIPE_DEPTH out of range");
  end
  if (LOAD_FWD_SLOT < 0 || LOAD_FWD_SLOT >= PIPE_DEPTH) begin : g_bad_load_slot
    $error("hazard_scoreboard: LOAD_FWD_SLOT out of range");
  end

  logic [PIPE_DEPTH-1:0] slot_valid;
  logic [PIPE_DEPTH-1:0] slot_load;
  logic [IDX_W-1:0]      slot_idx [PIPE_DEPTH];

  logic match_a, match_b;
  logic load_a, load_b;
  int   k_a, k_b;
  logic haz_a, haz_b;
  logic accept;
  logic [SEL_W-1:0] valid_count;

  // Scan oldest to youngest so the youngest producer overwrites earlier matches.
  always_comb begin
    match_a = 1'b0;
    match_b = 1'b0;
    load_a  = 1'b0;
    load_b  = 1'b0;
    k_a     = 0;
    k_b     = 0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      if (slot_valid[k] && (slot_idx[k] == id_ra_idx)) begin
        match_a = 1'b1;
        load_a  = slot_load[k];
        k_a     = k;
      end
      if (slot_valid[k] && (slot_idx[k] == id_rb_idx)) begin
        match_b = 1'b1;
        load_b  = slot_load[k];
        k_b     = k;
      end
    end
    if (!id_ra_used || (id_ra_idx == '0)) match_a = 1'b0;
    if (!id_rb_used || (id_rb_idx == '0)) match_b = 1'b0;
  end

  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    if (FWD_EN != 0) begin
      haz_a = match_a && load_a && (k_a < LOAD_FWD_SLOT);
      haz_b = match_b && load_b && (k_b < LOAD_FWD_SLOT);
    end else begin
      haz_a = match_a && !((WB_BYPASS != 0) && (k_a == PIPE_DEPTH - 1));
      haz_b = match_b && !((WB_BYPASS != 0) && (k_b == PIPE_DEPTH - 1));
    end
  end

  assign stall  = (haz_a | haz_b) & id_valid & ~flush & ~rst;
  assign accept = id_valid & ~stall & ~flush;

  // A stalled instruction re-evaluates next cycle, so its selects are meaningless now.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    if ((FWD_EN != 0) && !stall && !rst) begin
      if (match_a) fwd_a_sel = SEL_W'(k_a + 1);
      if (match_b) fwd_b_sel = SEL_W'(k_b + 1);
    end
  end

  // Flush kills slot 0 on its way into slot 1; older slots keep shifting untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
      slot_load  <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) slot_idx[k] <= '0;
    end else begin
      slot_valid[0] <= accept && id_reg_wr && (id_dest_idx != '0);
      slot_load[0]  <= id_rd_mem;
      slot_idx[0]   <= id_dest_idx;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        slot_valid[k] <= (k == 1) ? (slot_valid[0] & ~flush) : slot_valid[k-1];
        slot_load[k]  <= slot_load[k-1];
        slot_idx[k]   <= slot_idx[k-1];
      end
    end
  end

  always_comb begin
    valid_count = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (slot_valid[k]) valid_count = valid_count + SEL_W'(1);
    end
  end

  assign inflight_cnt = rst ? '0 : valid_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: three scoreboard configurations share one stimulus stream and are
// compared every cycle against a queue-based model, plus directed scenarios with fixed answers.
module tb_hazard_scoreboard;

  localparam int PD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0;
  logic [4:0] id_ra_idx = '0;
  logic [4:0] id_rb_idx = '0;
  logic id_ra_used = 1'b0;
  logic id_rb_used = 1'b0;
  logic [4:0] id_dest_idx = '0;
  logic id_reg_wr = 1'b0;
  logic id_rd_mem = 1'b0;
  logic flush = 1'b0;

  logic st0, st1, st2;
  logic [1:0] a0, b0, a1, b1, a2, b2, n0, n1, n2;
  logic [3:0] c0;
  logic [31:0] c1, c2;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  // d0: forwarding, 4-bit counter; d1: stall-only; d2: stall-only with write-through regfile
  hazard_scoreboard #(.NUM_REGS(32), .IDX_W(5), .PIPE_DEPTH(PD), .FWD_EN(1), .WB_BYPASS(0),
                      .LOAD_FWD_SLOT(2), .CNT_W(4)) d0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx),
    .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .id_dest_idx(id_dest_idx),
    .id_reg_wr(id_reg_wr), .id_rd_mem(id_rd_mem), .flush(flush), .stall(st0),
    .fwd_a_sel(a0), .fwd_b_sel(b0), .inflight_cnt(n0), .stall_cycles(c0));

  hazard_scoreboard #(.NUM_REGS(32), .IDX_W(5), .PIPE_DEPTH(PD), .FWD_EN(0), .WB_BYPASS(0),
                      .LOAD_FWD_SLOT(2), .CNT_W(32)) d1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx),
    .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .id_dest_idx(id_dest_idx),
    .id_reg_wr(id_reg_wr), .id_rd_mem(id_rd_mem), .flush(flush), .stall(st1),
    .fwd_a_sel(a1), .fwd_b_sel(b1), .inflight_cnt(n1), .stall_cycles(c1));

  hazard_scoreboard #(.NUM_REGS(32), .IDX_W(5), .PIPE_DEPTH(PD), .FWD_EN(0), .WB_BYPASS(1),
                      .LOAD_FWD_SLOT(2), .CNT_W(32)) d2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx),
    .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .id_dest_idx(id_dest_idx),
    .id_reg_wr(id_reg_wr), .id_rd_mem(id_rd_mem), .flush(flush), .stall(st2),
    .fwd_a_sel(a2), .fwd_b_sel(b2), .inflight_cnt(n2), .stall_cycles(c2));

  // Model: per configuration, an age-ordered list of in-flight instructions (index 0 youngest)
  typedef struct { bit v; int idx; bit ld; } ent_t;
  ent_t pipe [3][$];
  longint m_cnt [3];
  int p_fwd [3] = '{1, 0, 0};
  int p_wbb [3] = '{0, 0, 1};
  int p_lfs [3] = '{2, 2, 2};
  longint p_max [3] = '{64'd15, 64'hFFFF_FFFF, 64'hFFFF_FFFF};

  function automatic void modelClear(int i);
    ent_t e;
    e.v = 1'b0; e.idx = 0; e.ld = 1'b0;
    pipe[i].delete();
    for (int k = 0; k < PD; k++) pipe[i].push_back(e);
    m_cnt[i] = 0;
  endfunction

  function automatic int youngestWriter(int i, int s_idx, bit used);
    if (!used || s_idx == 0) return -1;
    for (int k = 0; k < PD; k++)
      if (pipe[i][k].v && pipe[i][k].idx == s_idx) return k;
    return -1;
  endfunction

  function automatic bit isHazard(int i, int k);
    if (k < 0) return 1'b0;
    if (p_fwd[i] != 0) return pipe[i][k].ld && (k < p_lfs[i]);
    return !((p_wbb[i] != 0) && (k == PD - 1));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic compareModel();
    for (int i = 0; i < 3; i++) begin
      int ka, kb, pop;
      bit st;
      logic [63:0] sa, sb;
      logic g_st;
      logic [1:0] g_a, g_b, g_n;
      logic [31:0] g_c;
      ent_t e;
      ka = youngestWriter(i, int'(id_ra_idx), id_ra_used);
      kb = youngestWriter(i, int'(id_rb_idx), id_rb_used);
      st = (isHazard(i, ka) || isHazard(i, kb)) && id_valid && !flush && !rst;
      sa = (p_fwd[i] != 0 && !st && !rst && ka >= 0) ? 64'(ka + 1) : 64'd0;
      sb = (p_fwd[i] != 0 && !st && !rst && kb >= 0) ? 64'(kb + 1) : 64'd0;
      pop = 0;
      for (int k = 0; k < PD; k++) if (pipe[i][k].v) pop++;
      if (rst) pop = 0;
      case (i)
        0: begin g_st = st0; g_a = a0; g_b = b0; g_n = n0; g_c = {28'd0, c0}; end
        1: begin g_st = st1; g_a = a1; g_b = b1; g_n = n1; g_c = c1; end
        default: begin g_st = st2; g_a = a2; g_b = b2; g_n = n2; g_c = c2; end
      endcase
      checkOutput($sformatf("stall[d%0d]", i), {63'd0, g_st}, {63'd0, st});
      checkOutput($sformatf("inflight[d%0d]", i), {62'd0, g_n}, 64'(pop));
      if (!flush) begin
        checkOutput($sformatf("fwd_a[d%0d]", i), {62'd0, g_a}, sa);
        checkOutput($sformatf("fwd_b[d%0d]", i), {62'd0, g_b}, sb);
      end
      if (!rst) checkOutput($sformatf("stall_cycles[d%0d]", i), {32'd0, g_c}, 64'(m_cnt[i]));
      // advance the model to what the next clock edge produces
      if (rst) begin
        modelClear(i);
      end else begin
        if (flush) pipe[i][0].v = 1'b0;
        e.v = id_valid && !st && !flush && id_reg_wr && (id_dest_idx != 0);
        e.idx = int'(id_dest_idx);
        e.ld = id_rd_mem;
        pipe[i].push_front(e);
        void'(pipe[i].pop_back());
        if (st && m_cnt[i] < p_max[i]) m_cnt[i]++;
      end
    end
  endtask

  always @(negedge clk) if (check_en) compareModel();

  task automatic applyStimulus(input bit v, input int ra, input int rb, input bit ua, input bit ub,
                               input int dest, input bit wr, input bit ld, input bit fl, input bit r);
    @(posedge clk);
    #1;
    id_valid = v; id_ra_idx = 5'(ra); id_rb_idx = 5'(rb); id_ra_used = ua; id_rb_used = ub;
    id_dest_idx = 5'(dest); id_reg_wr = wr; id_rd_mem = ld; flush = fl; rst = r;
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  logic [4:0] pat0, pat1, pat2;
  logic [1:0] sa_cap, sb_cap;
  bit seen;

  initial begin
    for (int i = 0; i < 3; i++) modelClear(i);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("reset_inflight", {62'd0, n0}, 64'd0);
    checkOutput("reset_count", {60'd0, c0}, 64'd0);

    // add x5, then a reader of x5 held in ID
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    pat0 = '0; pat1 = '0; pat2 = '0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
      pat0[c] = st0; pat1[c] = st1; pat2[c] = st2;
    end
    checkOutput("raw_stall_only_pattern", {59'd0, pat1}, 64'b00111);
    checkOutput("raw_wb_bypass_pattern", {59'd0, pat2}, 64'b00011);
    checkOutput("raw_forwarding_pattern", {59'd0, pat0}, 64'b00000);
    checkOutput("raw_stall_cycles", {32'd0, c1}, 64'd3);

    // lw x7; add x8,x7,x7 under forwarding
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    pat0 = '0; sa_cap = '0; sb_cap = '0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 7, 7, 1, 1, 8, 1, 0, 0, 0);
      pat0[c] = st0;
      if (c == 2) begin sa_cap = a0; sb_cap = b0; end
    end
    checkOutput("load_use_pattern", {59'd0, pat0}, 64'b00011);
    checkOutput("load_use_fwd_a", {62'd0, sa_cap}, 64'd3);
    checkOutput("load_use_fwd_b", {62'd0, sb_cap}, 64'd3);

    // add x3; sub x4,x3,x0
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    applyStimulus(1, 3, 0, 1, 1, 4, 1, 0, 0, 0);
    checkOutput("alu_fwd_stall", {63'd0, st0}, 64'd0);
    checkOutput("alu_fwd_a", {62'd0, a0}, 64'd1);
    checkOutput("alu_fwd_b_x0", {62'd0, b0}, 64'd0);

    // add x9; addi x9,x1; reader of x9 picks the youngest producer
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 9, 1, 0, 0, 0);
    applyStimulus(1, 9, 0, 1, 0, 10, 1, 0, 0, 0);
    checkOutput("youngest_producer_sel", {62'd0, a0}, 64'd1);

    // flush on a load-use hazard
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    applyStimulus(1, 7, 0, 1, 0, 8, 1, 0, 1, 0);
    checkOutput("flush_stall", {63'd0, st0}, 64'd0);
    checkOutput("flush_inflight_before", {62'd0, n0}, 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("flush_killed_slot", {62'd0, n0}, 64'd0);

    // self-dependent load keeps stalling until the 4-bit counter saturates
    doReset();
    for (int c = 0; c < 30; c++) applyStimulus(1, 7, 0, 1, 0, 7, 1, 1, 0, 0);
    checkOutput("count_saturated", {60'd0, c0}, 64'd15);
    seen = st0;
    for (int c = 0; c < 4 && !seen; c++) begin
      applyStimulus(1, 7, 0, 1, 0, 7, 1, 1, 0, 0);
      seen = st0;
    end
    checkOutput("stall_before_reset", {63'd0, seen}, 64'd1);
    applyStimulus(1, 7, 0, 1, 0, 7, 1, 1, 0, 1);
    checkOutput("in_reset_stall", {63'd0, st0}, 64'd0);
    checkOutput("in_reset_inflight", {62'd0, n0}, 64'd0);
    checkOutput("in_reset_fwd_a", {62'd0, a0}, 64'd0);
    applyStimulus(1, 7, 0, 1, 0, 7, 1, 1, 0, 0);
    checkOutput("post_reset_stall", {63'd0, st0}, 64'd0);
    checkOutput("post_reset_inflight", {62'd0, n0}, 64'd0);
    checkOutput("post_reset_count", {60'd0, c0}, 64'd0);

    // randomized traffic over a small register window to provoke frequent matches
    for (int c = 0; c < 3000; c++) begin
      bit wr;
      wr = ($urandom % 4) != 0;
      applyStimulus(($urandom % 4) != 0, int'($urandom % 8), int'($urandom % 8),
                    $urandom % 2 == 1, $urandom % 2 == 1, int'($urandom % 8), wr,
                    wr && ($urandom % 3 == 0), ($urandom % 16) == 0, ($urandom % 128) == 0);
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
